// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD init path: table entry layout, entry kinds
// and the panel opcodes used by the default init table.
package lcd_pkg;

  typedef enum logic [1:0] {
    KIND_CMD   = 2'b00,
    KIND_DATA  = 2'b01,
    KIND_DELAY = 2'b10,
    KIND_END   = 2'b11
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [7:0] val;
  } entry_t;

  localparam logic [7:0] SWRESET = 8'h01;
  localparam logic [7:0] SLPOUT  = 8'h11;
  localparam logic [7:0] PIXFMT  = 8'h3A;
  localparam logic [7:0] MADCTL  = 8'h36;
  localparam logic [7:0] DISPON  = 8'h29;

  function automatic entry_t mk_entry(input kind_e kind, input logic [7:0] val);
    entry_t e;
    e.kind = kind;
    e.val  = val;
    return e;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Init table with a registered read of the addressed entry and a registered
// lookahead of the kind of the following entry.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] addr_i,
  output entry_t        entry_o,
  output kind_e         next_kind_o
);

  localparam int unsigned Depth = 2 ** AW;

  typedef entry_t [Depth-1:0] table_t;

  function automatic entry_t lookup(input logic [AW-1:0] a);
    entry_t e;
    case (a)
      AW'(0):  e = mk_entry(KIND_CMD,   SWRESET);
      AW'(1):  e = mk_entry(KIND_DELAY, 8'd5);
      AW'(2):  e = mk_entry(KIND_CMD,   SLPOUT);
      AW'(3):  e = mk_entry(KIND_DELAY, 8'd120);
      AW'(4):  e = mk_entry(KIND_CMD,   PIXFMT);
      AW'(5):  e = mk_entry(KIND_DATA,  8'h55);
      AW'(6):  e = mk_entry(KIND_CMD,   MADCTL);
      AW'(7):  e = mk_entry(KIND_DATA,  8'h48);
      AW'(8):  e = mk_entry(KIND_CMD,   DISPON);
      default: e = mk_entry(KIND_END,   8'h00);
    endcase
    return e;
  endfunction

  function automatic table_t build_table();
    table_t t;
    for (int i = 0; i < int'(Depth); i++) begin
      t[i] = lookup(AW'(i));
    end
    return t;
  endfunction

  localparam table_t InitTable = build_table();

  entry_t entry_q;
  kind_e  next_kind_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q     <= '0;
      next_kind_q <= KIND_CMD;
    end else begin
      entry_q     <= InitTable[addr_i];
      next_kind_q <= InitTable[addr_i + AW'(1)].kind;
    end
  end

  assign entry_o     = entry_q;
  assign next_kind_o = next_kind_q;

endmodule

// File: rtl/lcd_init_seq.sv
// Panel bring-up sequencer: pulses the hardware reset, then walks the init
// table handing bytes to spi_cmd over the we/done handshake.
module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = 50000,
  parameter int unsigned RST_LOW_MS   = 10,
  parameter int unsigned RST_WAIT_MS  = 120,
  parameter int unsigned ROM_AW       = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_done,
  output logic [7:0] o_cmd,
  output logic       o_we,
  output logic       o_need_delay,
  output logic       o_dc,
  output logic       o_lcd_rst,
  output logic       o_busy,
  output logic       o_init_done
);

  localparam int unsigned CntW = 32;
  localparam logic [CntW-1:0] RstLowCycles  = CntW'(RST_LOW_MS * TICKS_PER_MS);
  localparam logic [CntW-1:0] RstWaitCycles = CntW'(RST_WAIT_MS * TICKS_PER_MS);
  localparam logic [ROM_AW-1:0] PtrLast     = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_FETCH,
    S_ISSUE,
    S_WAIT_DONE,
    S_DELAY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ROM_AW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   dly_tgt_q, dly_tgt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              we_q, we_d;
  logic              need_delay_q, need_delay_d;
  logic              dc_q, dc_d;
  logic              lcd_rst_q, lcd_rst_d;
  logic              busy_q, busy_d;
  logic              init_done_q, init_done_d;

  entry_t cur_entry;
  kind_e  next_kind;
  logic   is_end;
  logic   next_is_data;

  // Addressed with ptr_d so the entry at ptr is ready during FETCH.
  lcd_init_rom #(
    .AW(ROM_AW)
  ) u_rom (
    .clk_i      (i_clk),
    .rst_ni     (i_rst),
    .addr_i     (ptr_d),
    .entry_o    (cur_entry),
    .next_kind_o(next_kind)
  );

  // The last slot always acts as END, so a lookahead into it never chains DATA.
  assign is_end       = (cur_entry.kind == KIND_END) || (ptr_q == PtrLast);
  assign next_is_data = (next_kind == KIND_DATA) && (ptr_q != PtrLast - ROM_AW'(1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      dly_tgt_q    <= '0;
      cmd_q        <= '0;
      we_q         <= 1'b0;
      need_delay_q <= 1'b0;
      dc_q         <= 1'b0;
      lcd_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      dly_tgt_q    <= dly_tgt_d;
      cmd_q        <= cmd_d;
      we_q         <= we_d;
      need_delay_q <= need_delay_d;
      dc_q         <= dc_d;
      lcd_rst_q    <= lcd_rst_d;
      busy_q       <= busy_d;
      init_done_q  <= init_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    dly_tgt_d    = dly_tgt_q;
    cmd_d        = cmd_q;
    we_d         = 1'b0;
    need_delay_d = need_delay_q;
    dc_d         = dc_q;
    lcd_rst_d    = lcd_rst_q;
    busy_d       = busy_q;
    init_done_d  = init_done_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d     = S_RST_LOW;
          ptr_d       = '0;
          cnt_d       = '0;
          lcd_rst_d   = 1'b0;
          busy_d      = 1'b1;
          init_done_d = 1'b0;
        end
      end
      S_RST_LOW: begin
        if (cnt_q + CntW'(1) >= RstLowCycles) begin
          state_d   = S_RST_WAIT;
          cnt_d     = '0;
          lcd_rst_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_RST_WAIT: begin
        if (cnt_q + CntW'(1) >= RstWaitCycles) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_FETCH: begin
        if (is_end) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          init_done_d = 1'b1;
        end else if (cur_entry.kind == KIND_DELAY) begin
          state_d   = S_DELAY;
          cnt_d     = '0;
          dly_tgt_d = CntW'(cur_entry.val) * CntW'(TICKS_PER_MS);
        end else begin
          state_d      = S_ISSUE;
          we_d         = 1'b1;
          cmd_d        = cur_entry.val;
          dc_d         = (cur_entry.kind == KIND_DATA);
          need_delay_d = !next_is_data;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_DONE;
        cnt_d   = '0;
      end
      S_WAIT_DONE: begin
        // The first cycle after the strobe may still show the previous byte's done.
        if (cnt_q == '0) begin
          cnt_d = CntW'(1);
        end else if (i_done) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          ptr_d   = ptr_q + ROM_AW'(1);
        end
      end
      S_DELAY: begin
        if (cnt_q + CntW'(1) >= dly_tgt_q) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          ptr_d   = ptr_q + ROM_AW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_cmd        = cmd_q;
  assign o_we         = we_q;
  assign o_need_delay = need_delay_q;
  assign o_dc         = dc_q;
  assign o_lcd_rst    = lcd_rst_q;
  assign o_busy       = busy_q;
  assign o_init_done  = init_done_q;

endmodule
